// File: rtl/gex_decay_unit.sv
// Excitatory conductance update: gex' = gex - (gex*DeltaT)/Tauex + pending weights.
// Multi-cycle: one multiply cycle, a DATA_WIDTH-step restoring divider, then a single update cycle.
module gex_decay_unit #(
    parameter int INTEGER_WIDTH   = 32,
    parameter int DATA_WIDTH_FRAC = 32,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int DELTAT_WIDTH    = 4
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           Start,
    output logic                           Ready,
    input  logic signed [DATA_WIDTH-1:0]   gexIn,
    input  logic        [DELTAT_WIDTH-1:0] DeltaT,
    input  logic signed [INTEGER_WIDTH-1:0] Tauex,
    input  logic                           WeightValid,
    input  logic signed [DATA_WIDTH-1:0]   Weight,
    output logic signed [DATA_WIDTH-1:0]   gexOut,
    output logic                           Done,
    output logic                           DivErr
);

    localparam int RW = INTEGER_WIDTH + 1;
    localparam int PW = DATA_WIDTH + DELTAT_WIDTH + 1;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MULT   = 2'd1,
        S_DIV    = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0]    gex_q, gex_d;
    logic        [DELTAT_WIDTH-1:0]  dt_q, dt_d;
    logic signed [INTEGER_WIDTH-1:0] tau_q, tau_d;
    logic        [DATA_WIDTH-1:0]    dvd_q, dvd_d;
    logic        [INTEGER_WIDTH-1:0] rem_q, rem_d;
    logic        [DATA_WIDTH-1:0]    quo_q, quo_d;
    logic                            neg_q, neg_d;
    logic        [CW-1:0]            cnt_q, cnt_d;
    logic signed [DATA_WIDTH-1:0]    gout_q, gout_d;
    logic                            done_q, done_d;
    logic                            err_q, err_d;
    logic signed [DATA_WIDTH-1:0]    acc_q, acc_d;

    logic signed [PW-1:0]         gex_ext, dt_ext, prod;
    logic signed [DATA_WIDTH-1:0] p_mult;
    logic        [RW-1:0]         rem_sh, div_ext;
    logic                         q_bit;
    logic                         div_err;
    logic signed [DATA_WIDTH-1:0] decay;

    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? ((~x) + DATA_WIDTH'(1)) : x;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] apply_sign(input logic [DATA_WIDTH-1:0] mag,
                                                                 input logic neg);
        return neg ? $signed((~mag) + DATA_WIDTH'(1)) : $signed(mag);
    endfunction

    // DeltaT is unsigned, so it is zero-extended before the signed multiply.
    assign gex_ext = PW'(gex_q);
    assign dt_ext  = $signed(PW'({1'b0, dt_q}));
    assign prod    = gex_ext * dt_ext;
    assign p_mult  = DATA_WIDTH'(prod >>> DELTAT_WIDTH);

    assign rem_sh  = {rem_q, dvd_q[DATA_WIDTH-1]};
    assign div_ext = {1'b0, tau_q};
    assign q_bit   = (rem_sh >= div_ext);

    assign div_err = (tau_q <= 0);
    assign decay   = div_err ? '0 : apply_sign(quo_q, neg_q);

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (Start) state_d = S_MULT;
            S_MULT:   state_d = S_DIV;
            S_DIV:    if (cnt_q == LAST_BIT) state_d = S_UPDATE;
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        Ready = (state_q == S_IDLE);
    end

    always_comb begin
        gex_d  = gex_q;
        dt_d   = dt_q;
        tau_d  = tau_q;
        dvd_d  = dvd_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        neg_d  = neg_q;
        cnt_d  = cnt_q;
        gout_d = gout_q;
        done_d = 1'b0;
        err_d  = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    gex_d = gexIn;
                    dt_d  = DeltaT;
                    tau_d = Tauex;
                end
            end
            S_MULT: begin
                neg_d = p_mult[DATA_WIDTH-1];
                dvd_d = magnitude(p_mult);
                rem_d = '0;
                quo_d = '0;
                cnt_d = '0;
            end
            S_DIV: begin
                rem_d = q_bit ? INTEGER_WIDTH'(rem_sh - div_ext) : INTEGER_WIDTH'(rem_sh);
                quo_d = {quo_q[DATA_WIDTH-2:0], q_bit};
                dvd_d = {dvd_q[DATA_WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
            end
            S_UPDATE: begin
                gout_d = gex_q - decay + acc_q;
                done_d = 1'b1;
                err_d  = div_err;
            end
            default: ;
        endcase
    end

    // The accumulator is swapped out on the edge leaving UPDATE; a weight on that edge seeds the next sum.
    always_comb begin
        acc_d = acc_q;
        if (state_q == S_UPDATE) begin
            acc_d = WeightValid ? Weight : '0;
        end else if (WeightValid) begin
            acc_d = acc_q + Weight;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            gex_q  <= '0;
            dt_q   <= '0;
            tau_q  <= '0;
            dvd_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            gout_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            acc_q  <= '0;
        end else begin
            gex_q  <= gex_d;
            dt_q   <= dt_d;
            tau_q  <= tau_d;
            dvd_q  <= dvd_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            neg_q  <= neg_d;
            cnt_q  <= cnt_d;
            gout_q <= gout_d;
            done_q <= done_d;
            err_q  <= err_d;
            acc_q  <= acc_d;
        end
    end

    assign gexOut = gout_q;
    assign Done   = done_q;
    assign DivErr = err_q;

endmodule
